// File: rtl/led_pkg.sv
// Shared constants for the LED frame writer.
//   NUM_LANES   : lanes (columns) in the arrow field
//   NUM_ROWS    : rows per lane; notes enter row 0 and leave after row NUM_ROWS-1
//   HIT_ROW     : row judged against the lane buttons
//   FRAME_W     : width of the frame bus (32 green + 4 orange)
//   ORANGE_BASE : frame index of the orange bit for lane 0
//   frame_idx() : frame bit index of green lane/row
package led_pkg;

  localparam int NUM_LANES   = 4;
  localparam int NUM_ROWS    = 8;
  localparam int HIT_ROW     = 6;
  localparam int FRAME_W     = 36;
  localparam int ORANGE_BASE = 32;
  localparam int ROW_W       = 3;

  typedef logic [NUM_LANES-1:0] lane_mask_t;
  typedef logic [NUM_LANES-1:0][NUM_ROWS-1:0] field_t;

  function automatic int frame_idx(input int lane, input int row);
    return lane * NUM_ROWS + row;
  endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Row-scan timer for the LED array driver.
//   CLOCK : system clock
//   RESET : synchronous, active-high reset
//   COUNT : current scan row 0..7 (bit 3 is always 0)
//   fb    : one-cycle strobe in the cycle whose closing edge wraps COUNT 7->0
// Parameter SCAN_DIV (>=2) is the number of clock cycles each row is shown.
module led_scan_timer
  import led_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  output logic [3:0] COUNT,
  output logic       fb
);

  localparam int PW = $clog2(SCAN_DIV);

  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("led_scan_timer: SCAN_DIV must be >= 2");
  end

  logic [PW-1:0]    pre;
  logic [ROW_W-1:0] row;
  logic             tc;

  assign tc    = (pre == PW'(SCAN_DIV - 1));
  assign fb    = tc && (row == ROW_W'(NUM_ROWS - 1));
  assign COUNT = {1'b0, row};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      pre <= '0;
      row <= '0;
    end else if (tc) begin
      pre <= '0;
      row <= row + 1'b1;  // 3-bit row wraps 7->0 on its own
    end else begin
      pre <= pre + 1'b1;
    end
  end

endmodule

// File: rtl/led_frame_writer.sv
// Writer end of the LED scan interface: keeps a 4-lane x 8-row scrolling note
// field, accepts note masks from the sequencer, judges button presses at the
// hit row and publishes a tear-free 36-bit frame once per scan.
//   CLOCK      : system clock
//   RESET      : synchronous, active-high reset
//   note_valid : sequencer offers note_lane
//   note_lane  : lane mask of the offered note (bit c = lane c)
//   note_ready : writer can take a note this cycle (nothing pending)
//   btn        : one-cycle press pulses per lane
//   COUNT      : current scan row 0..7
//   frame      : [c*8+r] green lane c row r, [32+c] orange lane c
//   hit_pulse  : registered, high the cycle after a judged hit
//   miss_pulse : registered, high the cycle after a note scrolls out of row 7
// Build option LED_FRAME_HIT_FLASH_EN: orange bit c is a flash that stays lit
// for FLASH_FRMS frames after a hit on lane c. Without it, orange bit c shows
// any press of btn[c] seen since the previous frame boundary.
module led_frame_writer
  import led_pkg::*;
#(
  parameter int SCAN_DIV    = 1000,
  parameter int SCROLL_FRMS = 16,
  parameter int FLASH_FRMS  = 4
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 note_valid,
  input  logic [NUM_LANES-1:0] note_lane,
  output logic                 note_ready,
  input  logic [NUM_LANES-1:0] btn,
  output logic [3:0]           COUNT,
  output logic [FRAME_W-1:0]   frame,
  output logic [NUM_LANES-1:0] hit_pulse,
  output logic [NUM_LANES-1:0] miss_pulse
);

  localparam int SW = (SCROLL_FRMS > 1) ? $clog2(SCROLL_FRMS) : 1;

  if (SCROLL_FRMS < 1) begin : g_bad_scroll
    $error("led_frame_writer: SCROLL_FRMS must be >= 1");
  end
  if (FLASH_FRMS < 1) begin : g_bad_flash
    $error("led_frame_writer: FLASH_FRMS must be >= 1");
  end

  logic       fb;
  logic       step;
  field_t     field, field_next;
  lane_mask_t pending;
  lane_mask_t hit_now, miss_now;
  lane_mask_t orange;
  logic [SW-1:0] scroll_cnt;

  led_scan_timer #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .COUNT(COUNT),
    .fb   (fb)
  );

  assign step       = fb && (scroll_cnt == SW'(SCROLL_FRMS - 1));
  assign note_ready = (pending == '0);

  // Judge first, then scroll: a bit hit in the step cycle is already cleared
  // and cannot reach row 7 or produce a miss.
  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    field_next = field;
    hit_now    = '0;
    miss_now   = '0;
    for (int c = 0; c < NUM_LANES; c++) begin
      hit_now[c] = btn[c] & field[c][HIT_ROW];
      if (hit_now[c]) field_next[c][HIT_ROW] = 1'b0;
    end
    if (step) begin
      for (int c = 0; c < NUM_LANES; c++) begin
        miss_now[c]   = field_next[c][NUM_ROWS-1];
        field_next[c] = {field_next[c][NUM_ROWS-2:0], pending[c]};
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      // NOTE: the field is a small flop array, not a RAM, so it is cleared by
      // reset together with the rest of the state.
      field      <= '0;
      pending    <= '0;
      scroll_cnt <= '0;
      frame      <= '0;
      hit_pulse  <= '0;
      miss_pulse <= '0;
    end else begin
      field      <= field_next;
      hit_pulse  <= hit_now;
      miss_pulse <= miss_now;
      if (fb) scroll_cnt <= step ? '0 : scroll_cnt + 1'b1;
      // A step empties pending; a same-cycle transfer (possible only because
      // pending was already empty) refills it and wins.
      if (step) pending <= '0;
      if (note_valid && note_ready) pending <= note_lane;
      // Green comes from the post-step field so a note appears in row 0 at the
      // very boundary of its step; orange reflects state held up to the edge.
      if (fb) frame <= {orange, field_next};
    end
  end

`ifdef LED_FRAME_HIT_FLASH_EN
  localparam int FW = $clog2(FLASH_FRMS + 1);

  logic [NUM_LANES-1:0][FW-1:0] flash_cnt;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      flash_cnt <= '0;
    end else begin
      for (int c = 0; c < NUM_LANES; c++) begin
        if (hit_now[c])                   flash_cnt[c] <= FW'(FLASH_FRMS);
        else if (fb && flash_cnt[c] != '0) flash_cnt[c] <= flash_cnt[c] - 1'b1;
      end
    end
  end

  always_comb begin
    orange = '0;
    for (int c = 0; c < NUM_LANES; c++) orange[c] = (flash_cnt[c] != '0);
  end
`else
  lane_mask_t press;

  // Presses are collected until the next boundary shows them; a press in the
  // boundary cycle itself is kept for the following frame.
  always_ff @(posedge CLOCK) begin
    if (RESET) press <= '0;
    else       press <= (fb ? '0 : press) | btn;
  end

  assign orange = press;
`endif

endmodule

// File: tb/tb_led_frame_writer.sv
module tb_led_frame_writer;

  localparam int SCAN_DIV    = 2;
  localparam int SCROLL_FRMS = 1;
  localparam int FLASH_FRMS  = 2;
  localparam int FB_PERIOD   = SCAN_DIV * 8;

  logic        CLOCK;
  logic        RESET;
  logic        note_valid;
  logic [3:0]  note_lane;
  logic        note_ready;
  logic [3:0]  btn;
  logic [3:0]  COUNT;
  logic [35:0] frame;
  logic [3:0]  hit_pulse;
  logic [3:0]  miss_pulse;

  led_frame_writer #(
    .SCAN_DIV   (SCAN_DIV),
    .SCROLL_FRMS(SCROLL_FRMS),
    .FLASH_FRMS (FLASH_FRMS)
  ) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .note_valid(note_valid),
    .note_lane (note_lane),
    .note_ready(note_ready),
    .btn       (btn),
    .COUNT     (COUNT),
    .frame     (frame),
    .hit_pulse (hit_pulse),
    .miss_pulse(miss_pulse)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int checks   = 0;
  int failures = 0;
  int k        = 0;      // edges since the last reset edge
  bit in_reset = 1'b1;

  // Scoreboard: expected frames keyed by boundary edge, expected {hit,miss}
  // keyed by edge; filled when stimulus is driven, consumed by the monitor.
  logic [35:0] exp_frame [int];
  logic [7:0]  exp_pulse [int];
  logic [35:0] exp_hold;
  bit          hold_known;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got=%0h expected=%0h", tag, k, got, exp);
    end
  endtask

  function automatic logic [35:0] lane_bits(input logic [3:0] mask, input int row);
    logic [35:0] v = '0;
    for (int c = 0; c < 4; c++)
      if (mask[c]) v |= 36'd1 << (c * 8 + row);
    return v;
  endfunction

  task automatic push_frame(input int at, input logic [35:0] v);
    if (exp_frame.exists(at)) exp_frame[at] |= v;
    else                      exp_frame[at] = v;
  endtask

  task automatic push_pulse(input int at, input logic [3:0] hit, input logic [3:0] miss);
    if (exp_pulse.exists(at)) exp_pulse[at] |= {hit, miss};
    else                      exp_pulse[at] = {hit, miss};
  endtask

  task automatic monitor();
    logic [7:0] ep;
    check("count", 64'(COUNT), 64'((k / SCAN_DIV) % 8));
    ep = 8'h00;
    if (exp_pulse.exists(k)) begin
      ep = exp_pulse[k];
      exp_pulse.delete(k);
    end
    check("pulses", 64'({hit_pulse, miss_pulse}), 64'(ep));
    if (k % FB_PERIOD == 0) begin
      if (exp_frame.exists(k)) begin
        exp_hold   = exp_frame[k];
        hold_known = 1'b1;
        exp_frame.delete(k);
      end else begin
        hold_known = 1'b0;
      end
    end
    if (hold_known) check("frame", 64'(frame), 64'(exp_hold));
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
    k++;
    if (!in_reset) monitor();
  endtask

  task automatic run_until(input int target);
    while (k < target) tick();
  endtask

  task automatic send_note(input logic [3:0] mask);
    note_valid = 1'b1;
    note_lane  = mask;
    tick();
    note_valid = 1'b0;
    note_lane  = 4'h0;
  endtask

  task automatic press(input logic [3:0] mask);
    btn = mask;
    tick();
    btn = 4'h0;
  endtask

  task automatic release_reset();
    RESET      = 1'b0;
    in_reset   = 1'b0;
    k          = 0;
    exp_frame.delete();
    exp_pulse.delete();
    exp_hold   = '0;
    hold_known = 1'b1;
    check("rst_count", 64'(COUNT), 64'd0);
    check("rst_frame", 64'(frame), 64'd0);
    check("rst_ready", 64'(note_ready), 64'd1);
    check("rst_pulses", 64'({hit_pulse, miss_pulse}), 64'd0);
  endtask

  initial begin
    RESET      = 1'b1;
    note_valid = 1'b0;
    note_lane  = 4'h0;
    btn        = 4'h0;
    repeat (3) tick();
    release_reset();

    // Idle scan: COUNT steps every SCAN_DIV clocks, frame stays blank.
    push_frame(16, '0);
    push_frame(32, '0);
    repeat (40) begin
      tick();
      check("idle_ready", 64'(note_ready), 64'd1);
    end

    // Note on lanes 0 and 2 scrolls through all rows and is missed.
    for (int r = 0; r < 8; r++) push_frame(48 + 16 * r, lane_bits(4'b0101, r));
    push_frame(176, '0);
    push_pulse(176, 4'b0000, 4'b0101);
    send_note(4'b0101);
    check("ready_after_accept", 64'(note_ready), 64'd0);
    run_until(47);
    check("ready_before_step", 64'(note_ready), 64'd0);
    run_until(48);
    check("ready_after_step", 64'(note_ready), 64'd1);
    run_until(180);

    // Lane 2 note hit at row 6: cleared, no miss, orange indicator.
    for (int r = 0; r < 7; r++) push_frame(192 + 16 * r, lane_bits(4'b0100, r));
    send_note(4'b0100);
    run_until(290);
    check("row6_lane2_set", 64'(frame[22]), 64'd1);
    push_pulse(291, 4'b0100, 4'b0000);
`ifdef LED_FRAME_HIT_FLASH_EN
    push_frame(304, 36'd1 << 34);
    push_frame(320, 36'd1 << 34);
`else
    push_frame(304, 36'd1 << 34);
    push_frame(320, '0);
`endif
    push_frame(336, '0);
    press(4'b0100);
    run_until(340);

    // Lane 0 hit in the step cycle; press on empty lane 1 is ignored.
    for (int r = 0; r < 7; r++) push_frame(352 + 16 * r, lane_bits(4'b0001, r));
    send_note(4'b0001);
    run_until(463);
    push_pulse(464, 4'b0001, 4'b0000);
    push_frame(464, '0);
`ifdef LED_FRAME_HIT_FLASH_EN
    push_frame(480, 36'd1 << 32);
    push_frame(496, 36'd1 << 32);
`else
    push_frame(480, (36'd1 << 32) | (36'd1 << 33));
    push_frame(496, '0);
`endif
    push_frame(512, '0);
    press(4'b0011);
    run_until(520);

    // Notes in flight and a pending mask, then reset mid-frame.
    push_frame(528, lane_bits(4'hF, 0));
    push_frame(544, lane_bits(4'hF, 1) | lane_bits(4'b0010, 0));
    push_frame(560, lane_bits(4'hF, 2) | lane_bits(4'b0010, 1));
    push_frame(576, lane_bits(4'hF, 3) | lane_bits(4'b0010, 2));
    send_note(4'hF);
    run_until(530);
    send_note(4'b0010);
    check("ready_pending", 64'(note_ready), 64'd0);
    run_until(580);
    send_note(4'b1000);
    check("ready_pending2", 64'(note_ready), 64'd0);
    run_until(590);
    in_reset = 1'b1;
    RESET    = 1'b1;
    tick();
    release_reset();
    push_frame(16, '0);
    push_frame(32, '0);
    run_until(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
